// File: rtl/spi_config_port.sv
// -----------------------------------------------------------------------------
// spi_config_port
//
// SPI mode-0 slave giving an external master byte access to a configuration
// memory, a small set of ready flags and a sticky address-error bit.  The SNN
// core reads the flat memory image and the flags directly.
//
// Ports
//   SCLK          SPI clock, the only clock of the block. MOSI is sampled on
//                 the rising edge, MISO is launched on the falling edge.
//   RESET         asynchronous active-high reset of everything
//   SS            active-low slave select; high aborts the frame immediately
//                 (FSM, bit counter and shift registers only)
//   MOSI          serial data in, MSB first
//   MISO          serial data out, MSB first, 0 when nothing is being read
//   flags_out     ready flags (0 = clk_div, 1 = input_spike, 2 = debug_config)
//   addr_err      sticky: an access fell outside MEM_DEPTH
//   all_data_out  flat memory image, byte k at bits [8k+7:8k]
//
// Frame: instruction, [addr MSB, addr LSB], data*
//   0x01 WRITE  0x02 READ  0x05 READ_STATUS
//   0x10+k SET_FLAG k   0x20+k CLR_FLAG k   0x30 CLR_ERR
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | SS high or just fell; first sampled bit moves to INSTR
// INSTR  | collecting the instruction byte, decoded on its last bit
// ADDR_H | collecting the address MSB
// ADDR_L | collecting the address LSB; completion loads the address
// DATA   | burst data bytes (write or read, chosen by the opcode)
// STATUS | every completed byte reloads the live status byte
// IGNORE | remaining bytes of the frame have no effect
// -----------------------------------------------------------------------------
module spi_config_port #(
    parameter int MEM_DEPTH = 320,
    parameter int ADDR_W    = 16,
    parameter int NUM_FLAGS = 3,
    parameter int AUTO_WRAP = 1
) (
    input  logic                   SCLK,
    input  logic                   RESET,
    input  logic                   SS,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [NUM_FLAGS-1:0]   flags_out,
    output logic                   addr_err,
    output logic [MEM_DEPTH*8-1:0] all_data_out
);

    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_STATUS  = 8'h05;
    localparam logic [7:0] OP_CLR_ERR = 8'h30;
    localparam logic [3:0] GRP_SET    = 4'h1;
    localparam logic [3:0] GRP_CLR    = 4'h2;

    localparam logic [31:0]       DEPTH_U   = MEM_DEPTH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INSTR,
        S_ADDR_H,
        S_ADDR_L,
        S_DATA,
        S_STATUS,
        S_IGNORE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 w_fsm_rst;
    logic [2:0]           r_bit_cnt;
    logic [6:0]           r_rx_shift;
    logic [7:0]           r_addr_h;
    logic                 r_is_read;
    logic [7:0]           r_tx_shift;
    logic                 r_miso;

    logic [ADDR_W-1:0]    r_addr;
    logic [7:0]           r_mem [MEM_DEPTH];
    logic [NUM_FLAGS-1:0] r_flags;
    logic                 r_addr_err;

    logic                 w_byte_done;
    logic [7:0]           w_byte;
    logic [15:0]          w_addr_full;
    logic [ADDR_W-1:0]    w_acc_addr;
    logic                 w_in_range;
    logic [7:0]           w_rd_data;
    logic [7:0]           w_status;

    logic                 w_do_write;
    logic                 w_do_read;
    logic                 w_load_addr;
    logic                 w_set_flag;
    logic                 w_clr_flag;
    logic                 w_clr_err;
    logic                 w_status_load;

    // Frame-level logic is held in reset while SS is high, so a partial byte
    // never completes and the next frame always starts from bit 0.
    assign w_fsm_rst   = RESET | SS;

    // The byte completes on the edge that samples its 8th bit, so the
    // incoming MOSI bit is appended combinationally.
    assign w_byte      = {r_rx_shift, MOSI};
    assign w_byte_done = (r_bit_cnt == 3'd7);
    assign w_addr_full = {r_addr_h, w_byte};

    // On the ADDR_L completing edge the access uses the address being loaded,
    // which gives a read its first data byte with no dead byte.
    assign w_acc_addr  = w_load_addr ? w_addr_full[ADDR_W-1:0] : r_addr;
    assign w_in_range  = ({{(32-ADDR_W){1'b0}}, w_acc_addr} < DEPTH_U);

    function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] a);
        if ((AUTO_WRAP != 0) && (a == LAST_ADDR)) begin
            return '0;
        end
        return a + ADDR_W'(1);
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge SCLK or posedge w_fsm_rst) begin
        if (w_fsm_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_do_write    = 1'b0;
        w_do_read     = 1'b0;
        w_load_addr   = 1'b0;
        w_set_flag    = 1'b0;
        w_clr_flag    = 1'b0;
        w_clr_err     = 1'b0;
        w_status_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_INSTR;
            end
            S_INSTR: begin
                if (w_byte_done) begin
                    if ((w_byte == OP_WRITE) || (w_byte == OP_READ)) begin
                        w_state_nxt = S_ADDR_H;
                    end else if (w_byte == OP_STATUS) begin
                        w_state_nxt   = S_STATUS;
                        w_status_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IGNORE;
                        w_set_flag  = (w_byte[7:4] == GRP_SET);
                        w_clr_flag  = (w_byte[7:4] == GRP_CLR);
                        w_clr_err   = (w_byte == OP_CLR_ERR);
                    end
                end
            end
            S_ADDR_H: begin
                if (w_byte_done) begin
                    w_state_nxt = S_ADDR_L;
                end
            end
            S_ADDR_L: begin
                if (w_byte_done) begin
                    w_state_nxt = S_DATA;
                    w_load_addr = 1'b1;
                    w_do_read   = r_is_read;
                end
            end
            S_DATA: begin
                if (w_byte_done) begin
                    w_do_write = ~r_is_read;
                    w_do_read  = r_is_read;
                end
            end
            S_STATUS: begin
                w_status_load = w_byte_done;
            end
            S_IGNORE: begin
                w_state_nxt = S_IGNORE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------- frame-level datapath
    always_ff @(posedge SCLK or posedge w_fsm_rst) begin
        if (w_fsm_rst) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_addr_h   <= '0;
            r_is_read  <= 1'b0;
            r_tx_shift <= '0;
        end else begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_rx_shift <= w_byte[6:0];
            if ((r_state == S_INSTR) && w_byte_done) begin
                r_is_read <= (w_byte == OP_READ);
            end
            if ((r_state == S_ADDR_H) && w_byte_done) begin
                r_addr_h <= w_byte;
            end
            // Zero fill keeps MISO low once the loaded byte has been sent.
            if (w_byte_done) begin
                if (w_do_read) begin
                    r_tx_shift <= w_rd_data;
                end else if (w_status_load) begin
                    r_tx_shift <= w_status;
                end else begin
                    r_tx_shift <= '0;
                end
            end else begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
        end
    end

    always_ff @(negedge SCLK or posedge w_fsm_rst) begin
        if (w_fsm_rst) begin
            r_miso <= 1'b0;
        end else begin
            r_miso <= r_tx_shift[7];
        end
    end

    // ------------------------------------------- memory, flags, address
    // Address decode by comparison: out-of-range addresses simply match no
    // byte, so writes drop and reads return zero.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < MEM_DEPTH; k++) begin
            if (w_acc_addr == ADDR_W'(k)) begin
                w_rd_data = r_mem[k];
            end
        end
    end

    always_comb begin
        w_status                  = '0;
        w_status[NUM_FLAGS-1:0]   = r_flags;
        w_status[7]               = r_addr_err;
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < MEM_DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_flags    <= '0;
            r_addr_err <= 1'b0;
            r_addr     <= '0;
        end else begin
            for (int k = 0; k < MEM_DEPTH; k++) begin
                if (w_do_write && (w_acc_addr == ADDR_W'(k))) begin
                    r_mem[k] <= w_byte;
                end
            end

            for (int k = 0; k < NUM_FLAGS; k++) begin
                if (w_set_flag && (w_byte[3:0] == 4'(k))) begin
                    r_flags[k] <= 1'b1;
                end else if (w_clr_flag && (w_byte[3:0] == 4'(k))) begin
                    r_flags[k] <= 1'b0;
                end
            end

            if (w_clr_err) begin
                r_addr_err <= 1'b0;
            end else if ((w_do_write || w_do_read) && !w_in_range) begin
                r_addr_err <= 1'b1;
            end

            if (w_do_write || w_do_read) begin
                r_addr <= f_inc(w_acc_addr);
            end else if (w_load_addr) begin
                r_addr <= w_acc_addr;
            end
        end
    end

    // ------------------------------------------------------------ outputs
    for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_flat
        assign all_data_out[8*g +: 8] = r_mem[g];
    end

    assign MISO      = r_miso;
    assign flags_out = r_flags;
    assign addr_err  = r_addr_err;

endmodule
